// File: rtl/conv_line_feeder_if.sv
// Pixel-stream input and window-register column output of the convolution line feeder.
interface conv_line_feeder_if #(
  parameter int K_H = 3,
  parameter int DW  = 8,
  parameter int RW  = 5,
  parameter int CW  = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           in_data;
  logic [0:K_H-1][DW-1:0]  col_data;
  logic                    col_load;
  logic                    win_clear;
  logic                    win_valid;
  logic [RW-1:0]           out_row;
  logic [CW-1:0]           out_col;

  modport master (
    output in_valid, in_data,
    input  in_ready, col_data, col_load, win_clear, win_valid, out_row, out_col
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, col_data, col_load, win_clear, win_valid, out_row, out_col
  );
endinterface

// File: rtl/conv_line_feeder.sv
// Buffers K_H-1 image rows and turns a raster pixel stream into K_H-tall columns
// for the sliding-window register, flagging loads that complete a valid window.
module conv_line_feeder #(
  parameter int K_H   = 3,
  parameter int K_W   = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  conv_line_feeder_if.slave bus,
  output logic              busy,
  output logic              done
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic                   run_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   win_clear_r;
  logic                   col_load_r;
  logic                   win_valid_r;
  logic [RW-1:0]          row_r;
  logic [CW-1:0]          col_r;
  logic [RW-1:0]          out_row_r;
  logic [CW-1:0]          out_col_r;
  logic [0:K_H-1][DW-1:0] col_data_r;
  logic [DW-1:0]          lb_mem [K_H-1][IMG_W];

  logic in_ready_s;
  logic accept_s;
  logic win_hit_s;
  logic last_s;

  assign in_ready_s = run_r & ~stall;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign win_hit_s  = (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
  assign last_s     = (row_r == ROW_LAST) && (col_r == COL_LAST);

  assign bus.in_ready  = in_ready_s;
  assign bus.col_data  = col_data_r;
  assign bus.col_load  = col_load_r;
  assign bus.win_clear = win_clear_r;
  assign bus.win_valid = win_valid_r;
  assign bus.out_row   = out_row_r;
  assign bus.out_col   = out_col_r;
  assign busy          = busy_r;
  assign done          = done_r;

  // Frame sequencing, raster counters and the registered column/window outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      run_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      win_clear_r <= 1'b0;
      col_load_r  <= 1'b0;
      win_valid_r <= 1'b0;
      row_r       <= '0;
      col_r       <= '0;
      out_row_r   <= '0;
      out_col_r   <= '0;
      col_data_r  <= '0;
    end else begin
      win_clear_r <= 1'b0;
      col_load_r  <= 1'b0;
      win_valid_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_RUN;
            run_r       <= 1'b1;
            busy_r      <= 1'b1;
            row_r       <= '0;
            col_r       <= '0;
            win_clear_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            col_load_r  <= 1'b1;
            win_valid_r <= win_hit_s;
            // Older rows come from the line buffer before this cycle's shift lands.
            for (int k = 0; k < K_H - 1; k++) begin
              col_data_r[k] <= lb_mem[k][col_r];
            end
            col_data_r[K_H-1] <= bus.in_data;
            if (win_hit_s) begin
              out_row_r <= row_r - ROW_FIRST;
              out_col_r <= col_r - COL_FIRST;
            end
            if (last_s) begin
              state_r <= ST_DONE;
              run_r   <= 1'b0;
              done_r  <= 1'b1;
            end
            if (col_r == COL_LAST) begin
              col_r <= '0;
              row_r <= row_r + 1'b1;
            end else begin
              col_r <= col_r + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          run_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Line-buffer shift: the column slot moves each row up one and takes the new pixel.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s) begin
      for (int k = 0; k < K_H - 2; k++) begin
        lb_mem[k][col_r] <= lb_mem[k+1][col_r];
      end
      lb_mem[K_H-2][col_r] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_conv_line_feeder.sv
// Bench for conv_line_feeder on a 4x4 image with a 3x3 kernel: directed table,
// stall/toggle/restart/reset sequences, and random traffic against a frame-level model.
module tb_conv_line_feeder;
  localparam int KH = 3, KW = 3, W = 4, H = 4, DW = 8, RW = 2, CW = 2;
  localparam int NPIX = W * H;

  logic clk, rst_n, start, stall, in_valid, busy, done;
  logic [DW-1:0] in_data;
  int n_vec = 0, n_err = 0;
  int cnt_load = 0, cnt_clear = 0, cnt_done = 0;

  conv_line_feeder_if #(.K_H(KH), .DW(DW), .RW(RW), .CW(CW)) bus ();
  assign bus.in_valid = in_valid;
  assign bus.in_data  = in_data;

  conv_line_feeder #(.K_H(KH), .K_W(KW), .IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .bus(bus), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Frame-level reference: pixel n of a frame sits at (n / W, n % W); a column holds
  // the pixels directly above it, and a window is complete once KH rows x KW cols exist.
  logic [DW-1:0] img [H][W];
  bit m_run = 0, m_busy = 0, p_load = 0, p_clear = 0, p_done = 0, e_wv = 0;
  bit e_ok [KH-1];
  logic [DW-1:0] e_col [KH-1];
  logic [DW-1:0] m_last = '0;
  int m_n = 0, m_orow = 0, m_ocol = 0;

  always @(negedge clk) begin
    int r, c;
    bit acc;
    chk("in_ready", bus.in_ready, m_run && !stall);
    chk("col_load", bus.col_load, p_load);
    chk("win_clear", bus.win_clear, p_clear);
    chk("done", done, p_done);
    chk("busy", busy, m_busy);
    chk("win_valid", bus.win_valid, p_load && e_wv);
    chk("out_row", bus.out_row, m_orow);
    chk("out_col", bus.out_col, m_ocol);
    chk("col_newest", bus.col_data[KH-1], m_last);
    if (p_load)
      for (int k = 0; k < KH - 1; k++)
        if (e_ok[k]) chk("col_older", bus.col_data[k], e_col[k]);
    cnt_load  += int'(bus.col_load);
    cnt_clear += int'(bus.win_clear);
    cnt_done  += int'(done);

    acc     = rst_n && m_run && !stall && in_valid;
    p_load  = acc;
    p_clear = rst_n && !m_busy && start;
    p_done  = acc && (m_n == NPIX - 1);
    if (acc) begin
      r = m_n / W;
      c = m_n % W;
      img[r][c] = in_data;
      e_wv = (r >= KH - 1) && (c >= KW - 1);
      for (int k = 0; k < KH - 1; k++) begin
        e_ok[k] = (r - (KH - 1) + k) >= 0;
        if (e_ok[k]) e_col[k] = img[r - (KH - 1) + k][c];
      end
      m_last = in_data;
      if (e_wv) begin
        m_orow = r - (KH - 1);
        m_ocol = c - (KW - 1);
      end
    end
    if (!rst_n) begin
      m_run = 0; m_busy = 0; m_n = 0; m_orow = 0; m_ocol = 0; m_last = '0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_run = 1; m_n = 0; end
    end else if (!m_run) begin
      m_busy = 0;
    end else if (acc) begin
      if (m_n == NPIX - 1) begin m_run = 0; m_n = 0; end
      else m_n++;
    end
  end

  typedef struct {
    logic [7:0] pix;
    logic       wv;
    logic [1:0] orow;
    logic [1:0] ocol;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] vm;
  } vec_t;
  vec_t tab [NPIX];

  // Unstalled frame of pixels 1..16, each load compared to the table one cycle later.
  task automatic run_table(input bit start_with_stall);
    int l0, c0, d0;
    l0 = cnt_load; c0 = cnt_clear; d0 = cnt_done;
    start = 1'b1; stall = start_with_stall;
    @(posedge clk); #1;
    start = 1'b0; stall = 1'b0;
    chk("tab_clear", bus.win_clear, 1);
    for (int i = 0; i < NPIX; i++) begin
      in_valid = 1'b1; in_data = tab[i].pix;
      @(posedge clk); #1;
      chk("tab_load", bus.col_load, 1);
      chk("tab_clear_low", bus.win_clear, 0);
      chk("tab_wvalid", bus.win_valid, tab[i].wv);
      chk("tab_done", done, i == NPIX - 1);
      chk("tab_col2", bus.col_data[2], tab[i].pix);
      if (tab[i].vm[0]) chk("tab_col0", bus.col_data[0], tab[i].c0);
      if (tab[i].vm[1]) chk("tab_col1", bus.col_data[1], tab[i].c1);
      if (tab[i].wv) begin
        chk("tab_orow", bus.out_row, tab[i].orow);
        chk("tab_ocol", bus.out_col, tab[i].ocol);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("tab_busy_end", busy, 0);
    chk("tab_ready_end", bus.in_ready, 0);
    chk("tab_load_end", bus.col_load, 0);
    chk("tab_nload", cnt_load - l0, NPIX);
    chk("tab_nclear", cnt_clear - c0, 1);
    chk("tab_ndone", cnt_done - d0, 1);
  endtask

  // Frame with optional 3-cycle stall after a pixel, toggling valid, or a stray start.
  task automatic run_frame(input int stall_after, input bit toggle, input int start_mid);
    int p, st, cyc, l0, c0, d0;
    bit ph, acc;
    l0 = cnt_load; c0 = cnt_clear; d0 = cnt_done;
    p = 1; st = 0; cyc = 0; ph = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    while (p <= NPIX && cyc < 200) begin
      stall = (st > 0);
      in_valid = toggle ? ph : 1'b1;
      in_data = 8'(p);
      start = (p == start_mid);
      @(negedge clk);
      acc = in_valid && bus.in_ready;
      if (stall) chk("stall_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      if (stall) begin
        st--;
        chk("stall_noload", bus.col_load, 0);
      end
      if (acc && p == stall_after) st = 3;
      if (acc) p++;
      ph = !ph;
      cyc++;
    end
    in_valid = 1'b0; stall = 1'b0; start = 1'b0;
    if (p <= NPIX) chk("frame_timeout", p, NPIX + 1);
    repeat (2) @(posedge clk);
    #1;
    chk("frm_busy_end", busy, 0);
    chk("frm_nload", cnt_load - l0, NPIX);
    chk("frm_nclear", cnt_clear - c0, 1);
    chk("frm_ndone", cnt_done - d0, 1);
  endtask

  initial begin
    tab[0]  = '{8'd1,  1'b0, 2'd0, 2'd0, 8'd0, 8'd0,  2'b00};
    tab[1]  = '{8'd2,  1'b0, 2'd0, 2'd0, 8'd0, 8'd0,  2'b00};
    tab[2]  = '{8'd3,  1'b0, 2'd0, 2'd0, 8'd0, 8'd0,  2'b00};
    tab[3]  = '{8'd4,  1'b0, 2'd0, 2'd0, 8'd0, 8'd0,  2'b00};
    tab[4]  = '{8'd5,  1'b0, 2'd0, 2'd0, 8'd0, 8'd1,  2'b10};
    tab[5]  = '{8'd6,  1'b0, 2'd0, 2'd0, 8'd0, 8'd2,  2'b10};
    tab[6]  = '{8'd7,  1'b0, 2'd0, 2'd0, 8'd0, 8'd3,  2'b10};
    tab[7]  = '{8'd8,  1'b0, 2'd0, 2'd0, 8'd0, 8'd4,  2'b10};
    tab[8]  = '{8'd9,  1'b0, 2'd0, 2'd0, 8'd1, 8'd5,  2'b11};
    tab[9]  = '{8'd10, 1'b0, 2'd0, 2'd0, 8'd2, 8'd6,  2'b11};
    tab[10] = '{8'd11, 1'b1, 2'd0, 2'd0, 8'd3, 8'd7,  2'b11};
    tab[11] = '{8'd12, 1'b1, 2'd0, 2'd1, 8'd4, 8'd8,  2'b11};
    tab[12] = '{8'd13, 1'b0, 2'd0, 2'd0, 8'd5, 8'd9,  2'b11};
    tab[13] = '{8'd14, 1'b0, 2'd0, 2'd0, 8'd6, 8'd10, 2'b11};
    tab[14] = '{8'd15, 1'b1, 2'd1, 2'd0, 8'd7, 8'd11, 2'b11};
    tab[15] = '{8'd16, 1'b1, 2'd1, 2'd1, 8'd8, 8'd12, 2'b11};

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_data", bus.col_data, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_table(1'b0);
    run_frame(6, 1'b0, 0);
    run_frame(0, 1'b1, 0);
    run_frame(0, 1'b0, 5);
    run_table(1'b0);

    // Reset for one cycle after pixel 9 abandons the frame.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int p = 1; p <= 9; p++) begin
      in_valid = 1'b1; in_data = 8'(p);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_data = 8'd10;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mid_rst_load", bus.col_load, 0);
    chk("mid_rst_wvalid", bus.win_valid, 0);
    chk("mid_rst_clear", bus.win_clear, 0);
    chk("mid_rst_orow", bus.out_row, 0);
    chk("mid_rst_ocol", bus.out_col, 0);
    chk("mid_rst_data", bus.col_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    run_table(1'b1);

    for (int i = 0; i < 1500; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      start    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; start = 1'b0; stall = 1'b0; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
